// File: rtl/key_debounce_ctrl_pkg.sv
// rtl/key_debounce_ctrl_pkg.sv - shared types and widths for the key debounce controller
// Contents:
//   MS_W, PRE_W   widths of the ms counter and of the 1 ms prescaler
//   key_state_t   FSM state encoding (3-bit)
//   edge_kind_t   which edge was seen last (H2L = push, L2H = release)
package key_debounce_ctrl_pkg;

    localparam int MS_W  = 11;
    localparam int PRE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_HELD         = 3'd2,
        ST_REPEAT       = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } key_state_t;

    typedef enum logic {
        EDGE_L2H = 1'b0,
        EDGE_H2L = 1'b1
    } edge_kind_t;

endpackage

// File: rtl/key_debounce_ctrl_if.sv
// rtl/key_debounce_ctrl_if.sv - edge-pulse inputs and key-event outputs of the debouncer
// Signals:
//   H2L_Sig, L2H_Sig     1-cycle edge pulses from the pin edge detector
//   Key_Press/Release    1-cycle confirmed press / release pulses
//   Key_Long, Key_Repeat 1-cycle long-press and auto-repeat pulses
//   Key_Level            debounced level, 1 = pressed
// Modports: master = edge detector / event consumer side, slave = debouncer.
interface key_debounce_ctrl_if;

    logic H2L_Sig;
    logic L2H_Sig;
    logic Key_Press;
    logic Key_Release;
    logic Key_Long;
    logic Key_Repeat;
    logic Key_Level;

    modport master (
        output H2L_Sig, L2H_Sig,
        input  Key_Press, Key_Release, Key_Long, Key_Repeat, Key_Level
    );

    modport slave (
        input  H2L_Sig, L2H_Sig,
        output Key_Press, Key_Release, Key_Long, Key_Repeat, Key_Level
    );

endinterface

// File: rtl/key_debounce_ctrl_ms_timer.sv
// rtl/key_debounce_ctrl_ms_timer.sv - 1 ms prescaler plus saturating millisecond counter
// Ports:
//   CLOCK    in   system clock, rising edge
//   RST_n    in   asynchronous active-low reset
//   clr      in   synchronous clear of prescaler and ms counter (beats ms_tick)
//   ms_tick  out  high in the cycle the prescaler sits at T1MS
//   ms_cnt   out  number of ms_ticks since the last clear, saturating
module key_debounce_ctrl_ms_timer
    import key_debounce_ctrl_pkg::*;
#(
    parameter logic [PRE_W-1:0] T1MS = 16'd49_999
) (
    input  logic            CLOCK,
    input  logic            RST_n,
    input  logic            clr,
    output logic            ms_tick,
    output logic [MS_W-1:0] ms_cnt
);

    logic [PRE_W-1:0] pre;

    assign ms_tick = (pre == T1MS);

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            pre    <= '0;
            ms_cnt <= '0;
        end else if (clr) begin
            pre    <= '0;
            ms_cnt <= '0;
        end else if (ms_tick) begin
            pre <= '0;
            // Hold at all-ones so a very long hold never looks like a fresh count.
            if (ms_cnt != '1) begin
                ms_cnt <= ms_cnt + MS_W'(1);
            end
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/key_debounce_ctrl.sv
// rtl/key_debounce_ctrl.sv - debounce and press/release/long/repeat sequencer for one push-button
// Ports:
//   CLOCK   in   system clock, rising edge
//   RST_n   in   asynchronous active-low reset
//   bus     slave modport: H2L_Sig/L2H_Sig in, Key_Press/Release/Long/Repeat/Level out
// All outputs are registered; the FSM, last_edge and output registers live here,
// timing comes from the ms_timer sub-module.
module key_debounce_ctrl
    import key_debounce_ctrl_pkg::*;
#(
    parameter logic [PRE_W-1:0] T1MS        = 16'd49_999,
    parameter logic [MS_W-1:0]  DEBOUNCE_MS = 11'd10,
    parameter logic [MS_W-1:0]  LONG_MS     = 11'd1000,
    parameter logic [MS_W-1:0]  REPEAT_MS   = 11'd200
) (
    input  logic                 CLOCK,
    input  logic                 RST_n,
    key_debounce_ctrl_if.slave   bus
);

    key_state_t      state;
    edge_kind_t      last_edge;
    logic            key_press;
    logic            key_release;
    logic            key_long;
    logic            key_repeat;
    logic            key_level;

    logic            clr;
    logic            ms_tick;
    logic [MS_W-1:0] ms_cnt;

    // Both pulses in one cycle cancel: the pin cannot have moved in a known direction.
    logic edge_h2l;
    logic edge_l2h;
    logic edge_any;
    assign edge_h2l = bus.H2L_Sig & ~bus.L2H_Sig;
    assign edge_l2h = bus.L2H_Sig & ~bus.H2L_Sig;
    assign edge_any = edge_h2l | edge_l2h;

    // Debounce expiry is seen one cycle after ms_cnt reaches the limit; long and
    // repeat fire on the tick itself so their pulse lands right after that tick.
    logic debounce_done;
    logic long_hit;
    logic repeat_hit;
    assign debounce_done = (ms_cnt == DEBOUNCE_MS) && !edge_any;
    assign long_hit      = ms_tick && (ms_cnt == LONG_MS - MS_W'(1));
    assign repeat_hit    = ms_tick && (ms_cnt == REPEAT_MS - MS_W'(1));

    // Timer restarts on every state change, on every edge accepted while
    // waiting, and on each repeat period.
    always_comb begin
        clr = 1'b0;
        case (state)
            ST_IDLE:         clr = edge_h2l;
            ST_PRESS_WAIT:   clr = edge_any | debounce_done;
            ST_HELD:         clr = edge_l2h | long_hit;
            ST_REPEAT:       clr = edge_l2h | repeat_hit;
            ST_RELEASE_WAIT: clr = edge_any | debounce_done;
            default:         clr = 1'b1;
        endcase
    end

    key_debounce_ctrl_ms_timer #(
        .T1MS (T1MS)
    ) u_ms_timer (
        .CLOCK   (CLOCK),
        .RST_n   (RST_n),
        .clr     (clr),
        .ms_tick (ms_tick),
        .ms_cnt  (ms_cnt)
    );

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= ST_IDLE;
            last_edge   <= EDGE_L2H;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
            key_level   <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (edge_h2l) begin
                        state     <= ST_PRESS_WAIT;
                        last_edge <= EDGE_H2L;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (edge_any) begin
                        last_edge <= edge_h2l ? EDGE_H2L : EDGE_L2H;
                    end else if (debounce_done) begin
                        if (last_edge == EDGE_H2L) begin
                            state     <= ST_HELD;
                            key_press <= 1'b1;
                            key_level <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HELD: begin
                    if (edge_l2h) begin
                        state     <= ST_RELEASE_WAIT;
                        last_edge <= EDGE_L2H;
                    end else if (long_hit) begin
                        state    <= ST_REPEAT;
                        key_long <= 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (edge_l2h) begin
                        state     <= ST_RELEASE_WAIT;
                        last_edge <= EDGE_L2H;
                    end else if (repeat_hit) begin
                        key_repeat <= 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (edge_any) begin
                        last_edge <= edge_h2l ? EDGE_H2L : EDGE_L2H;
                    end else if (debounce_done) begin
                        if (last_edge == EDGE_L2H) begin
                            state       <= ST_IDLE;
                            key_release <= 1'b1;
                            key_level   <= 1'b0;
                        end else begin
                            // Bounce back to pressed: long-press timing starts over.
                            state <= ST_HELD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Key_Press   = key_press;
    assign bus.Key_Release = key_release;
    assign bus.Key_Long    = key_long;
    assign bus.Key_Repeat  = key_repeat;
    assign bus.Key_Level   = key_level;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// tb/tb_key_debounce_ctrl.sv - self-checking bench for key_debounce_ctrl
module tb_key_debounce_ctrl;

    localparam int T1MS = 9;
    localparam int DEB  = 2;
    localparam int LNG  = 5;
    localparam int REP  = 3;
    localparam int MSP  = T1MS + 1;

    logic CLOCK;
    logic RST_n;

    key_debounce_ctrl_if bus();

    key_debounce_ctrl #(
        .T1MS        (16'(T1MS)),
        .DEBOUNCE_MS (11'(DEB)),
        .LONG_MS     (11'(LNG)),
        .REPEAT_MS   (11'(REP))
    ) dut (
        .CLOCK (CLOCK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: timing expressed as deadlines relative to the cycle the
    // timer last restarted, straight from the ms arithmetic of the key rules.
    typedef enum {M_IDLE, M_PW, M_HELD, M_REP, M_RW} mphase_t;
    mphase_t m_phase;
    int      m_anchor;
    bit      m_last_h2l;
    bit      e_press, e_rel, e_long, e_rep, e_level;

    // Observed pulse history for directed checks.
    int press_cnt, press_at, rel_cnt, rel_at, long_cnt, long_at;
    int rep_q[$];

    task automatic model_reset();
        m_phase = M_IDLE; m_anchor = 0; m_last_h2l = 1'b0;
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0; e_level = 0;
    endtask

    task automatic clear_events();
        press_cnt = 0; press_at = -1; rel_cnt = 0; rel_at = -1;
        long_cnt = 0; long_at = -1; rep_q.delete();
    endtask

    task automatic model_update(input bit h, input bit l);
        bit eh, el;
        eh = h & ~l;
        el = l & ~h;
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
        case (m_phase)
            M_IDLE: if (eh) begin m_phase = M_PW; m_anchor = cyc; m_last_h2l = 1; end
            M_PW, M_RW: begin
                if (eh | el) begin
                    m_anchor = cyc; m_last_h2l = eh;
                end else if (cyc == m_anchor + DEB * MSP + 1) begin
                    m_anchor = cyc;
                    if (m_phase == M_PW) begin
                        if (m_last_h2l) begin m_phase = M_HELD; e_press = 1; e_level = 1; end
                        else m_phase = M_IDLE;
                    end else begin
                        if (!m_last_h2l) begin m_phase = M_IDLE; e_rel = 1; e_level = 0; end
                        else m_phase = M_HELD;
                    end
                end
            end
            M_HELD: begin
                if (el) begin m_phase = M_RW; m_anchor = cyc; m_last_h2l = 0; end
                else if (cyc == m_anchor + LNG * MSP) begin m_phase = M_REP; m_anchor = cyc; e_long = 1; end
            end
            M_REP: begin
                if (el) begin m_phase = M_RW; m_anchor = cyc; m_last_h2l = 0; end
                else if (cyc == m_anchor + REP * MSP) begin m_anchor = cyc; e_rep = 1; end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic step(input bit h, input bit l);
        bus.H2L_Sig = h;
        bus.L2H_Sig = l;
        @(posedge CLOCK);
        cyc++;
        #1;
        bus.H2L_Sig = 1'b0;
        bus.L2H_Sig = 1'b0;
        model_update(h, l);
        check($sformatf("press@%0d", cyc),   int'(bus.Key_Press),   int'(e_press));
        check($sformatf("release@%0d", cyc), int'(bus.Key_Release), int'(e_rel));
        check($sformatf("long@%0d", cyc),    int'(bus.Key_Long),    int'(e_long));
        check($sformatf("repeat@%0d", cyc),  int'(bus.Key_Repeat),  int'(e_rep));
        check($sformatf("level@%0d", cyc),   int'(bus.Key_Level),   int'(e_level));
        if (bus.Key_Press)   begin press_cnt++; press_at = cyc; end
        if (bus.Key_Release) begin rel_cnt++;   rel_at   = cyc; end
        if (bus.Key_Long)    begin long_cnt++;  long_at  = cyc; end
        if (bus.Key_Repeat)  rep_q.push_back(cyc);
    endtask

    task automatic run_to(input int target, input bit h, input bit l);
        while (cyc < target - 1) step(0, 0);
        step(h, l);
    endtask

    task automatic idle_until(input int target);
        while (cyc < target) step(0, 0);
    endtask

    // Asserts reset between edges, checks outputs drop at once, holds 3 cycles.
    task automatic apply_reset(input string tag);
        #2;
        RST_n = 1'b0;
        bus.H2L_Sig = 1'b0;
        bus.L2H_Sig = 1'b0;
        #1;
        check({tag, "_press"},   int'(bus.Key_Press),   0);
        check({tag, "_release"}, int'(bus.Key_Release), 0);
        check({tag, "_long"},    int'(bus.Key_Long),    0);
        check({tag, "_repeat"},  int'(bus.Key_Repeat),  0);
        check({tag, "_level"},   int'(bus.Key_Level),   0);
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        RST_n = 1'b1;
        cyc = 0;
        model_reset();
        clear_events();
    endtask

    initial begin
        int gap, r;
        RST_n = 1'b0;
        bus.H2L_Sig = 1'b0;
        bus.L2H_Sig = 1'b0;
        model_reset();
        clear_events();
        @(posedge CLOCK);
        apply_reset("rst");

        // Clean press, hold into long/repeat, then release.
        run_to(100, 1, 0);
        idle_until(130);
        check("t1_press_cnt", press_cnt, 1);
        check("t1_press_at", press_at, 121);
        check("t1_level", int'(bus.Key_Level), 1);
        run_to(270, 0, 1);
        idle_until(400);
        check("t4_long_at", long_at, 171);
        check("t4_rep_cnt", rep_q.size(), 3);
        if (rep_q.size() == 3) begin
            check("t4_rep0", rep_q[0], 201);
            check("t4_rep1", rep_q[1], 231);
            check("t4_rep2", rep_q[2], 261);
        end
        check("t4_release_at", rel_at, 291);
        check("t4_level", int'(bus.Key_Level), 0);

        // Bounce on press: last edge decides.
        apply_reset("rst2");
        run_to(100, 1, 0);
        run_to(105, 0, 1);
        run_to(112, 1, 0);
        idle_until(200);
        check("t2_press_cnt", press_cnt, 1);
        check("t2_press_at", press_at, 133);

        // Glitch that settles released.
        apply_reset("rst3");
        run_to(100, 1, 0);
        run_to(110, 0, 1);
        idle_until(200);
        check("t3_press_cnt", press_cnt, 0);
        check("t3_level", int'(bus.Key_Level), 0);

        // Release bounce while held: no release, long timing restarts.
        apply_reset("rst5");
        run_to(100, 1, 0);
        run_to(300, 0, 1);
        run_to(305, 1, 0);
        idle_until(390);
        check("t5_release_cnt", rel_cnt, 0);
        check("t5_long_at", long_at, 376);
        check("t5_level", int'(bus.Key_Level), 1);

        // Simultaneous pulses are ignored, in IDLE and while debouncing.
        apply_reset("rst6a");
        run_to(50, 1, 1);
        run_to(100, 1, 0);
        run_to(115, 1, 1);
        idle_until(140);
        check("t6_both_press_at", press_at, 121);
        check("t6_both_press_cnt", press_cnt, 1);

        // Reset during PRESS_WAIT and during REPEAT.
        apply_reset("rst6b");
        run_to(100, 1, 0);
        idle_until(110);
        apply_reset("rst_pw");
        idle_until(100);
        run_to(100 + 1, 1, 0);
        idle_until(190);
        check("t6_level_rep", int'(bus.Key_Level), 1);
        apply_reset("rst_rep");
        idle_until(300);
        check("t6_post_press", press_cnt + rel_cnt + long_cnt + rep_q.size(), 0);

        // Random edge traffic against the reference model.
        apply_reset("rst_rand");
        for (int i = 0; i < 150; i++) begin
            gap = $urandom_range(0, 40);
            if ($urandom_range(0, 3) == 0) gap += $urandom_range(40, 120);
            repeat (gap) step(0, 0);
            r = $urandom_range(0, 99);
            if (r < 45)      step(1, 0);
            else if (r < 90) step(0, 1);
            else if (r < 96) step(1, 1);
            else             apply_reset("rst_r");
        end
        repeat (200) step(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
